// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
package whack_pkg;

    typedef enum logic [2:0] {
        ST_GAP,
        ST_SHOW,
        ST_HIT,
        ST_MISS,
        ST_OVER
    } state_t;

    // Right-shift Galois form of x^8+x^6+x^5+x^4+1 (maximal length, never reaches 0)
    localparam logic [7:0] LFSR_SEED = 8'hB8;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int SCORE_W = 14;
    localparam int MISS_W  = 2;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Galois LFSR used as the mole position generator; holds when en=0.
module lfsr8
    import whack_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {1'b0, q[7:1]} ^ (q[0] ? LFSR_TAPS : 8'h00);
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: picks a mole, lights it for a level-dependent time,
// judges switch presses and keeps the hit score and miss count.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int PRESC      = 100_000,
    parameter int HOLD_EASY  = 1000,
    parameter int HOLD_HARD  = 500,
    parameter int GAP        = 300,
    parameter int MAX_MISS   = 3,
    parameter int SCORE_MAX  = 9999,
    parameter int SCORE_INIT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pause,
    input  logic               lev,
    input  logic [7:0]         sw,
    output logic [7:0]         led,
    output logic [SCORE_W-1:0] score,
    output logic [MISS_W-1:0]  misses,
    output logic               hit_p,
    output logic               miss_p,
    output logic               game_over
);

    localparam int PW   = (PRESC > 2) ? $clog2(PRESC) : 1;
    localparam int HMAX = (HOLD_EASY > HOLD_HARD) ? HOLD_EASY : HOLD_HARD;
    localparam int TMAX = (HMAX > GAP) ? HMAX : GAP;
    localparam int TW   = $clog2(TMAX + 1);

    state_t       state;
    logic [PW-1:0] presc;
    logic          tick;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] hold_last;
    logic [7:0]    sw_q;
    logic [7:0]    rise;
    logic [7:0]    tgt_mask;
    logic [2:0]    target;
    logic [2:0]    cand;
    logic [2:0]    next_tgt;
    logic          hard;
    logic          hit_q;
    logic          miss_q;
    logic [7:0]    lfsr_q;
    logic          lfsr_unused;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        if (s >= SCORE_W'(SCORE_MAX))
            return SCORE_W'(SCORE_MAX);
        return s + 1'b1;
    endfunction

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!pause),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[7:3];

    assign tick      = !pause && (presc == PW'(PRESC - 1));
    assign rise      = sw & ~sw_q;
    assign tgt_mask  = 8'b1 << target;
    assign hold_last = hard ? TW'(HOLD_HARD - 1) : TW'(HOLD_EASY - 1);
    assign cand      = lfsr_q[2:0];
    assign next_tgt  = (cand == target) ? cand + 3'd1 : cand;

    // Pulses are suppressed while paused; the held HIT/MISS state re-emits them on release
    assign hit_p  = hit_q & ~pause;
    assign miss_p = miss_q & ~pause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (!pause) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q <= sw;
        end else begin
            sw_q <= sw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_GAP;
            led       <= '0;
            score     <= SCORE_W'(SCORE_INIT);
            misses    <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            game_over <= 1'b0;
            tick_cnt  <= '0;
            target    <= '0;
            hard      <= 1'b0;
        end else if (!pause) begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            case (state)
                ST_GAP: begin
                    if (tick) begin
                        if (tick_cnt == TW'(GAP - 1)) begin
                            target   <= next_tgt;
                            led      <= 8'b1 << next_tgt;
                            hard     <= lev;
                            tick_cnt <= '0;
                            state    <= ST_SHOW;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                ST_SHOW: begin
                    // Stray presses beat a correct one on the same cycle to defeat mashing
                    if ((|(rise & ~tgt_mask)) ||
                        (!(|(rise & tgt_mask)) && tick && tick_cnt == hold_last)) begin
                        state    <= ST_MISS;
                        miss_q   <= 1'b1;
                        misses   <= misses + 1'b1;
                        led      <= '0;
                        tick_cnt <= '0;
                    end else if (|(rise & tgt_mask)) begin
                        state    <= ST_HIT;
                        hit_q    <= 1'b1;
                        score    <= sat_inc(score);
                        led      <= '0;
                        tick_cnt <= '0;
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                ST_HIT: begin
                    state <= ST_GAP;
                end
                ST_MISS: begin
                    if (misses == MISS_W'(MAX_MISS)) begin
                        state     <= ST_OVER;
                        led       <= 8'hFF;
                        game_over <= 1'b1;
                    end else begin
                        state <= ST_GAP;
                    end
                end
                ST_OVER: begin
                    state <= ST_OVER;
                end
                default: begin
                    state <= ST_GAP;
                end
            endcase
        end
    end

endmodule
